// File: rtl/barrett_pkg.sv
// barrett_pkg: widths, limits and FSM states shared by the Barrett parameter generator and reducer
package barrett_pkg;
  localparam int Q_W = 64;
  localparam int MU_W = 31;
  localparam int K_W = 8;
  localparam int K_MAX = MU_W - 2;
  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;
endpackage

// File: rtl/msb_index.sv
// msb_index: combinational leading-one detector returning the top set bit index and an all-zero flag
module msb_index #(
  parameter int W = 64,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  x,
  output logic [IW-1:0] idx,
  output logic          zero
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) idx = x[i] ? IW'(i) : idx;
    zero = ~|x;
  end
endmodule

// File: rtl/barrett_param_gen.sv
// barrett_param_gen: computes k = bitlen(q) and mu = floor(2^(2k)/q) with a serial restoring divider
module barrett_param_gen
  import barrett_pkg::*;
#(
  parameter int Q_W = barrett_pkg::Q_W,
  parameter int MU_W = barrett_pkg::MU_W,
  parameter int K_W = barrett_pkg::K_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Q_W-1:0]  q,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [K_W-1:0]  k,
  output logic [MU_W-1:0] mu
);
  localparam int IW = $clog2(Q_W);
  localparam int K_LIM = MU_W - 2;
  state_t state, state_n;
  logic [Q_W-1:0] q_r;
  logic [K_W-1:0] k_r, k_n, cnt;
  logic [Q_W:0] rem, rem_n;
  logic [MU_W-1:0] quo;
  logic [IW-1:0] idx;
  logic zero, bad, ge, err_r;
  msb_index #(.W(Q_W), .IW(IW)) u_msb (.x(q_r), .idx(idx), .zero(zero));
  assign k_n = K_W'(idx) + K_W'(1);
  assign bad = zero | (k_n > K_W'(K_LIM));
  assign rem_n = {rem[Q_W-1:0], cnt == {k_r[K_W-2:0], 1'b0}};
  assign ge = rem[Q_W] | (rem_n >= {1'b0, q_r});
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? NORM : IDLE) :
              state == NORM ? (bad ? DONE : DIV) :
              state == DIV  ? (cnt == '0 ? DONE : DIV) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q_r <= '0;
      k_r <= '0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      err_r <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      k <= '0;
      mu <= '0;
    end else begin
      done <= state == DONE;
      if (state == IDLE && start) q_r <= q;
      if (state == NORM) begin
        k_r <= bad ? '0 : k_n;
        err_r <= bad;
        cnt <= {k_n[K_W-2:0], 1'b0};
        rem <= '0;
        quo <= '0;
      end
      if (state == DIV) begin
        rem <= ge ? rem_n - {1'b0, q_r} : rem_n;
        quo <= {quo[MU_W-2:0], ge};
        cnt <= cnt - K_W'(1);
      end
      if (state == DONE) begin
        mu <= quo;
        k <= k_r;
        err <= err_r;
      end
    end
endmodule

// File: tb/tb_barrett_param_gen.sv
// tb_barrett_param_gen: randomized self-checking bench against an arithmetic Barrett model
module tb_barrett_param_gen;
  import barrett_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [Q_W-1:0] q = '0;
  logic busy, done, err;
  logic [K_W-1:0] k;
  logic [MU_W-1:0] mu;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  barrett_param_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q),
    .busy(busy), .done(done), .err(err), .k(k), .mu(mu)
  );
  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int bitlen(input longint unsigned v);
    int n = 0;
    while (v != 0) begin
      n++;
      v >>= 1;
    end
    return n;
  endfunction
  task automatic run(input longint unsigned qv, input int poke);
    int kk, lat;
    bit bad_q, bz_ok;
    longint unsigned emu;
    kk = bitlen(qv);
    bad_q = kk == 0 || kk > K_MAX;
    emu = bad_q ? 0 : (64'd1 << (2 * kk)) / qv;
    @(negedge clk);
    q = qv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bz_ok = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (!done && !busy) bz_ok = 0;
      start = lat == poke;
      if (lat == poke) q = ~qv;
    end
    start = 1'b0;
    check($sformatf("lat q=%0d", qv), lat, bad_q ? 2 : 2 * kk + 3);
    check($sformatf("k q=%0d", qv), k, bad_q ? 0 : kk);
    check($sformatf("mu q=%0d", qv), mu, emu);
    check($sformatf("err q=%0d", qv), err, bad_q);
    check("busy_at_done", busy, 0);
    check("busy_span", bz_ok, 1);
    @(posedge clk);
    #1 check("done_pulse", done, 0);
  endtask
  initial begin
    int nd, gap, idle;
    longint unsigned rq;
    int kk;
    #2 rst_n = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      start = ~start;
      q = 13;
      @(posedge clk);
      #1 nd += done;
    end
    start = 1'b0;
    check("rst_done_seen", nd, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_k", k, 0);
    check("rst_mu", mu, 0);
    @(negedge clk) rst_n = 1'b1;
    run(13, -1);
    run(1000, -1);
    run(64'd1 << 28, -1);
    run(0, -1);
    run(64'd1 << 29, -1);
    run(13, 5);
    run(1000, 12);
    @(negedge clk);
    q = 13;
    start = 1'b1;
    gap = 0;
    while (!done && gap < 100) begin
      @(posedge clk);
      #1 gap++;
    end
    gap = 0;
    idle = 0;
    do begin
      @(posedge clk);
      #1 gap++;
      if (!busy) idle++;
    end while (!done && gap < 100);
    start = 1'b0;
    check("b2b_gap", gap, 12);
    check("b2b_idle", idle, 1);
    check("b2b_mu", mu, 19);
    repeat (3) @(posedge clk);
    @(negedge clk);
    q = 13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_k", k, 0);
    check("abort_mu", mu, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1 nd += done;
    end
    check("stale_done", nd, 0);
    run(8, -1);
    repeat (20) begin
      kk = $urandom_range(0, 36);
      rq = {$urandom(), $urandom()};
      rq = kk == 0 ? 0 : kk == 36 ? rq | (64'd1 << 63) :
           (64'd1 << (kk - 1)) | (rq & ((64'd1 << (kk - 1)) - 1));
      run(rq, $urandom_range(0, 1) == 1 ? 3 : -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
